// File: rtl/ddr_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_port_arbiter
//
// Two-master arbiter in front of a single Avalon-MM DDR3 controller slave.
//   m0 : VGA scan-out read master (read only, with an "urgent" hint that
//        wins arbitration when its line FIFO runs low).
//   m1 : HPS / pixel-writer master (reads and burst writes).
//
// Ports
//   clk_clk, reset_reset_n           clock, asynchronous active-low reset
//   m0_* / m1_*                      master-side Avalon command inputs,
//                                    waitrequest / readdatavalid outputs
//   rd_data                          slave read data, shared by both masters
//   ddr_*                            command to / response from DDR slave
//
// Grant is chosen combinationally in IDLE so a command reaches the slave in
// the cycle it is presented. Write bursts from m1 lock the grant (WBURST)
// until every beat is accepted. Read ownership is tracked by a 4-entry tag
// FIFO of {owner, burstcount}, which steers each returning beat.
// ---------------------------------------------------------------------------
module ddr_port_arbiter #(
    parameter int DW  = 128,
    parameter int AW  = 25,
    parameter int BCW = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [AW-1:0]     m0_address,
    input  logic              m0_read,
    input  logic [BCW-1:0]    m0_burstcount,
    input  logic              m0_urgent,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    input  logic [AW-1:0]     m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic [BCW-1:0]    m1_burstcount,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [DW-1:0]     rd_data,
    output logic [AW-1:0]     ddr_address,
    output logic              ddr_read,
    output logic              ddr_write,
    output logic [DW-1:0]     ddr_writedata,
    output logic [DW/8-1:0]   ddr_byteenable,
    output logic [BCW-1:0]    ddr_burstcount,
    input  logic              ddr_waitrequest,
    input  logic              ddr_readdatavalid,
    input  logic [DW-1:0]     ddr_readdata
);

    localparam logic [BCW-1:0] ONE_BC = {{(BCW-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, WBURST} state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;   // 0 = m0, 1 = m1
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;       // write beats still to go
    logic [BCW-1:0] ret_cnt_q, ret_cnt_d;         // beats returned for head tag

    // Tag FIFO
    logic           tag_owner_mem [4];
    logic [BCW-1:0] tag_bc_mem    [4];
    logic [1:0]     wr_ptr_q, rd_ptr_q;
    logic [2:0]     fifo_cnt_q;
    logic           fifo_full, fifo_empty;
    logic           push, pop, rdv_hit;
    logic [BCW:0]   ret_cnt_plus;

    logic [BCW-1:0] m0_bc_eff, m1_bc_eff;
    logic           m0_elig, m1_rd_elig, m1_elig;
    logic           grant_m1, issue_rd, issue_wr, accepted;

    // A zero burstcount is issued as a single beat.
    assign m0_bc_eff = (m0_burstcount == '0) ? ONE_BC : m0_burstcount;
    assign m1_bc_eff = (m1_burstcount == '0) ? ONE_BC : m1_burstcount;

    assign fifo_full  = (fifo_cnt_q == 3'd4);
    assign fifo_empty = (fifo_cnt_q == 3'd0);

    // Reads are not eligible while the tag FIFO is full; writes always are.
    assign m0_elig    = m0_read && !fifo_full;
    assign m1_rd_elig = m1_read && !fifo_full;
    assign m1_elig    = m1_write || m1_rd_elig;

    always_comb begin
        grant_m1       = 1'b0;
        issue_rd       = 1'b0;
        issue_wr       = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        beat_cnt_d     = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (m0_elig && m0_urgent)
                    grant_m1 = 1'b0;
                else if (m0_elig && m1_elig)
                    grant_m1 = !last_grant_q;   // tie: whoever did not go last
                else
                    grant_m1 = m1_elig;

                if (grant_m1 && m1_elig) begin
                    issue_rd       = m1_rd_elig && !m1_write;
                    issue_wr       = m1_write;
                    m1_waitrequest = ddr_waitrequest;
                end else if (!grant_m1 && m0_elig) begin
                    issue_rd       = 1'b1;
                    m0_waitrequest = ddr_waitrequest;
                end

                if ((issue_rd || issue_wr) && !ddr_waitrequest) begin
                    last_grant_d = grant_m1;
                    if (issue_wr && (m1_bc_eff != ONE_BC)) begin
                        state_d    = WBURST;
                        beat_cnt_d = m1_bc_eff - ONE_BC;
                    end
                end
            end

            WBURST: begin
                // Grant stays on m1 until the final write beat is taken.
                grant_m1       = 1'b1;
                issue_wr       = m1_write;
                m1_waitrequest = m1_write ? ddr_waitrequest : 1'b1;
                if (m1_write && !ddr_waitrequest) begin
                    beat_cnt_d = beat_cnt_q - ONE_BC;
                    if (beat_cnt_q == ONE_BC)
                        state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Hold both masters off and keep the slave idle while in reset.
        if (!reset_reset_n) begin
            issue_rd       = 1'b0;
            issue_wr       = 1'b0;
            m0_waitrequest = 1'b1;
            m1_waitrequest = 1'b1;
        end
    end

    assign accepted = (issue_rd || issue_wr) && !ddr_waitrequest;

    assign ddr_read       = issue_rd;
    assign ddr_write      = issue_wr;
    assign ddr_address    = grant_m1 ? m1_address : m0_address;
    assign ddr_burstcount = grant_m1 ? m1_bc_eff  : m0_bc_eff;
    assign ddr_writedata  = m1_writedata;
    assign ddr_byteenable = m1_byteenable;
    assign rd_data        = ddr_readdata;

    // Read return steering. Beats arriving with no tag are dropped.
    assign push         = issue_rd && accepted;
    assign rdv_hit      = reset_reset_n && ddr_readdatavalid && !fifo_empty;
    assign ret_cnt_plus = {1'b0, ret_cnt_q} + {{BCW{1'b0}}, 1'b1};
    assign pop          = rdv_hit && (ret_cnt_plus == {1'b0, tag_bc_mem[rd_ptr_q]});

    assign m0_readdatavalid = rdv_hit && !tag_owner_mem[rd_ptr_q];
    assign m1_readdatavalid = rdv_hit &&  tag_owner_mem[rd_ptr_q];

    always_comb begin
        ret_cnt_d = ret_cnt_q;
        if (pop)
            ret_cnt_d = '0;
        else if (rdv_hit)
            ret_cnt_d = ret_cnt_plus[BCW-1:0];
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            tag_owner_mem[wr_ptr_q] <= grant_m1;
            tag_bc_mem[wr_ptr_q]    <= ddr_burstcount;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            ret_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            ret_cnt_q    <= ret_cnt_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_port_arbiter
//
// Directed testbench for ddr_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are compared 2 units after the edge, well clear
// of the next rising edge.
// ---------------------------------------------------------------------------
module tb_ddr_port_arbiter;

    localparam int DW  = 128;
    localparam int AW  = 25;
    localparam int BCW = 8;

    logic            clk_clk = 1'b0;
    logic            reset_reset_n;
    logic [AW-1:0]   m0_address;
    logic            m0_read;
    logic [BCW-1:0]  m0_burstcount;
    logic            m0_urgent;
    logic            m0_waitrequest;
    logic            m0_readdatavalid;
    logic [AW-1:0]   m1_address;
    logic            m1_read;
    logic            m1_write;
    logic [DW-1:0]   m1_writedata;
    logic [DW/8-1:0] m1_byteenable;
    logic [BCW-1:0]  m1_burstcount;
    logic            m1_waitrequest;
    logic            m1_readdatavalid;
    logic [DW-1:0]   rd_data;
    logic [AW-1:0]   ddr_address;
    logic            ddr_read;
    logic            ddr_write;
    logic [DW-1:0]   ddr_writedata;
    logic [DW/8-1:0] ddr_byteenable;
    logic [BCW-1:0]  ddr_burstcount;
    logic            ddr_waitrequest;
    logic            ddr_readdatavalid;
    logic [DW-1:0]   ddr_readdata;

    int total = 0;
    int bad   = 0;

    ddr_port_arbiter #(.DW(DW), .AW(AW), .BCW(BCW)) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .m0_address        (m0_address),
        .m0_read           (m0_read),
        .m0_burstcount     (m0_burstcount),
        .m0_urgent         (m0_urgent),
        .m0_waitrequest    (m0_waitrequest),
        .m0_readdatavalid  (m0_readdatavalid),
        .m1_address        (m1_address),
        .m1_read           (m1_read),
        .m1_write          (m1_write),
        .m1_writedata      (m1_writedata),
        .m1_byteenable     (m1_byteenable),
        .m1_burstcount     (m1_burstcount),
        .m1_waitrequest    (m1_waitrequest),
        .m1_readdatavalid  (m1_readdatavalid),
        .rd_data           (rd_data),
        .ddr_address       (ddr_address),
        .ddr_read          (ddr_read),
        .ddr_write         (ddr_write),
        .ddr_writedata     (ddr_writedata),
        .ddr_byteenable    (ddr_byteenable),
        .ddr_burstcount    (ddr_burstcount),
        .ddr_waitrequest   (ddr_waitrequest),
        .ddr_readdatavalid (ddr_readdatavalid),
        .ddr_readdata      (ddr_readdata)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 1'b0; m0_urgent = 1'b0; m0_address = '0; m0_burstcount = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_burstcount = '0;
        m1_writedata = '0; m1_byteenable = '0;
        ddr_waitrequest = 1'b0; ddr_readdatavalid = 1'b0; ddr_readdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_reset_n = 1'b0;
        m0_read = 1'b1; m1_read = 1'b1; ddr_readdatavalid = 1'b1;
        repeat (2) @(posedge clk_clk);
        #2;
        if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_m0_wait got=%0h exp=1", m0_waitrequest); end total++;
        if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_m1_wait got=%0h exp=1", m1_waitrequest); end total++;
        if (ddr_read !== 1'b0) begin bad++; $display("FAIL reset_ddr_read got=%0h exp=0", ddr_read); end total++;
        if (ddr_write !== 1'b0) begin bad++; $display("FAIL reset_ddr_write got=%0h exp=0", ddr_write); end total++;
        if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_m0_rdv got=%0h exp=0", m0_readdatavalid); end total++;
        if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_m1_rdv got=%0h exp=0", m1_readdatavalid); end total++;
        step();
        idle_inputs();
        reset_reset_n = 1'b1;
        $display("test_reset: outputs held idle during reset");
    endtask

    // Simultaneous reads after reset: m0 first, then m1; beats in order.
    task automatic test_round_robin();
        step();
        m0_read = 1'b1; m0_burstcount = 8'd8; m0_address = 25'h100;
        m1_read = 1'b1; m1_burstcount = 8'd4; m1_address = 25'h200;
        #1;
        if (ddr_read !== 1'b1) begin bad++; $display("FAIL rr_first_read got=%0h exp=1", ddr_read); end total++;
        if (ddr_address !== 25'h100) begin bad++; $display("FAIL rr_first_addr got=%0h exp=100", ddr_address); end total++;
        if (ddr_burstcount !== 8'd8) begin bad++; $display("FAIL rr_first_bc got=%0h exp=8", ddr_burstcount); end total++;
        if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL rr_first_m0_wait got=%0h exp=0", m0_waitrequest); end total++;
        if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL rr_first_m1_wait got=%0h exp=1", m1_waitrequest); end total++;
        $display("test_round_robin: m0 read 0x100 x8 issued");
        step();
        m0_read = 1'b0;
        #1;
        if (ddr_read !== 1'b1) begin bad++; $display("FAIL rr_second_read got=%0h exp=1", ddr_read); end total++;
        if (ddr_address !== 25'h200) begin bad++; $display("FAIL rr_second_addr got=%0h exp=200", ddr_address); end total++;
        if (ddr_burstcount !== 8'd4) begin bad++; $display("FAIL rr_second_bc got=%0h exp=4", ddr_burstcount); end total++;
        if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL rr_second_m1_wait got=%0h exp=0", m1_waitrequest); end total++;
        $display("test_round_robin: m1 read 0x200 x4 issued");
        for (int i = 0; i < 12; i++) begin
            step();
            m1_read = 1'b0;
            ddr_readdatavalid = 1'b1;
            ddr_readdata = DW'(160 + i);
            #1;
            if (m0_readdatavalid !== (i < 8)) begin bad++; $display("FAIL rr_beat%0d_m0_rdv got=%0h exp=%0h", i, m0_readdatavalid, (i < 8)); end total++;
            if (m1_readdatavalid !== (i >= 8)) begin bad++; $display("FAIL rr_beat%0d_m1_rdv got=%0h exp=%0h", i, m1_readdatavalid, (i >= 8)); end total++;
            if (rd_data !== DW'(160 + i)) begin bad++; $display("FAIL rr_beat%0d_data got=%0h exp=%0h", i, rd_data, 160 + i); end total++;
            $display("test_round_robin: return beat %0d m0_rdv=%0b m1_rdv=%0b", i, m0_readdatavalid, m1_readdatavalid);
        end
        // One extra beat with nothing outstanding is dropped.
        step();
        #1;
        if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rr_stray_m0_rdv got=%0h exp=0", m0_readdatavalid); end total++;
        if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL rr_stray_m1_rdv got=%0h exp=0", m1_readdatavalid); end total++;
        step();
        idle_inputs();
    endtask

    // m1 write burst of 4 locks out an urgent m0 read until the last beat.
    task automatic test_write_burst();
        m1_write = 1'b1; m1_burstcount = 8'd4; m1_address = 25'h300;
        m1_writedata = DW'(1); m1_byteenable = '1;
        #1;
        if (ddr_write !== 1'b1) begin bad++; $display("FAIL wb_beat1_write got=%0h exp=1", ddr_write); end total++;
        if (ddr_address !== 25'h300) begin bad++; $display("FAIL wb_beat1_addr got=%0h exp=300", ddr_address); end total++;
        if (ddr_burstcount !== 8'd4) begin bad++; $display("FAIL wb_beat1_bc got=%0h exp=4", ddr_burstcount); end total++;
        if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL wb_beat1_m1_wait got=%0h exp=0", m1_waitrequest); end total++;
        $display("test_write_burst: write beat 1 accepted");
        for (int b = 2; b <= 4; b++) begin
            step();
            m0_read = 1'b1; m0_urgent = 1'b1; m0_burstcount = 8'd2; m0_address = 25'h40;
            m1_writedata = DW'(b);
            #1;
            if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL wb_beat%0d_m0_wait got=%0h exp=1", b, m0_waitrequest); end total++;
            if (ddr_read !== 1'b0) begin bad++; $display("FAIL wb_beat%0d_read got=%0h exp=0", b, ddr_read); end total++;
            if (ddr_write !== 1'b1) begin bad++; $display("FAIL wb_beat%0d_write got=%0h exp=1", b, ddr_write); end total++;
            if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL wb_beat%0d_m1_wait got=%0h exp=0", b, m1_waitrequest); end total++;
            if (ddr_writedata !== DW'(b)) begin bad++; $display("FAIL wb_beat%0d_wdata got=%0h exp=%0h", b, ddr_writedata, b); end total++;
            $display("test_write_burst: write beat %0d accepted, m0 stalled", b);
        end
        step();
        m1_write = 1'b0;
        #1;
        if (ddr_read !== 1'b1) begin bad++; $display("FAIL wb_m0_issue_read got=%0h exp=1", ddr_read); end total++;
        if (ddr_address !== 25'h40) begin bad++; $display("FAIL wb_m0_issue_addr got=%0h exp=40", ddr_address); end total++;
        if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL wb_m0_issue_wait got=%0h exp=0", m0_waitrequest); end total++;
        $display("test_write_burst: urgent m0 read issued after burst");
        for (int i = 0; i < 2; i++) begin
            step();
            m0_read = 1'b0; m0_urgent = 1'b0;
            ddr_readdatavalid = 1'b1;
            #1;
            if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL wb_ret%0d_m0_rdv got=%0h exp=1", i, m0_readdatavalid); end total++;
            $display("test_write_burst: m0 return beat %0d", i);
        end
        step();
        idle_inputs();
    endtask

    // Tag FIFO fills at 4 reads; writes still pass; pop frees a slot next cycle.
    task automatic test_fifo_full();
        for (int k = 0; k < 5; k++) begin
            m0_read = 1'b1; m0_burstcount = 8'd2; m0_address = AW'(32'h500 + k);
            #1;
            if (ddr_read !== (k < 4)) begin bad++; $display("FAIL ff_read%0d got=%0h exp=%0h", k, ddr_read, (k < 4)); end total++;
            if (m0_waitrequest !== (k >= 4)) begin bad++; $display("FAIL ff_wait%0d got=%0h exp=%0h", k, m0_waitrequest, (k >= 4)); end total++;
            $display("test_fifo_full: m0 read %0d ddr_read=%0b", k, ddr_read);
            step();
        end
        m1_write = 1'b1; m1_burstcount = 8'd0; m1_address = 25'h600;
        #1;
        if (ddr_write !== 1'b1) begin bad++; $display("FAIL ff_wr_write got=%0h exp=1", ddr_write); end total++;
        if (ddr_burstcount !== 8'd1) begin bad++; $display("FAIL ff_wr_bc got=%0h exp=1", ddr_burstcount); end total++;
        if (ddr_read !== 1'b0) begin bad++; $display("FAIL ff_wr_read got=%0h exp=0", ddr_read); end total++;
        if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL ff_wr_m1_wait got=%0h exp=0", m1_waitrequest); end total++;
        if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL ff_wr_m0_wait got=%0h exp=1", m0_waitrequest); end total++;
        $display("test_fifo_full: m1 write burstcount 0 issued as 1 while full");
        step();
        m1_write = 1'b0; ddr_readdatavalid = 1'b1;
        #1;
        if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL ff_ret1_rdv got=%0h exp=1", m0_readdatavalid); end total++;
        if (ddr_read !== 1'b0) begin bad++; $display("FAIL ff_ret1_read got=%0h exp=0", ddr_read); end total++;
        step();
        #1;
        if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL ff_ret2_rdv got=%0h exp=1", m0_readdatavalid); end total++;
        if (ddr_read !== 1'b0) begin bad++; $display("FAIL ff_ret2_read got=%0h exp=0", ddr_read); end total++;
        if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL ff_ret2_wait got=%0h exp=1", m0_waitrequest); end total++;
        $display("test_fifo_full: first burst returned, pop this cycle");
        step();
        ddr_readdatavalid = 1'b0;
        #1;
        if (ddr_read !== 1'b1) begin bad++; $display("FAIL ff_after_pop_read got=%0h exp=1", ddr_read); end total++;
        if (ddr_address !== 25'h504) begin bad++; $display("FAIL ff_after_pop_addr got=%0h exp=504", ddr_address); end total++;
        if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL ff_after_pop_wait got=%0h exp=0", m0_waitrequest); end total++;
        $display("test_fifo_full: held 5th read issued");
        for (int j = 0; j < 8; j++) begin
            step();
            m0_read = 1'b0; ddr_readdatavalid = 1'b1;
            #1;
            if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL ff_drain%0d_rdv got=%0h exp=1", j, m0_readdatavalid); end total++;
            $display("test_fifo_full: drain beat %0d", j);
        end
        step();
        idle_inputs();
    endtask

    // Slave stall on an m1 read, then read issue and final return beat together.
    task automatic test_waitrequest();
        for (int c = 0; c < 3; c++) begin
            m1_read = 1'b1; m1_burstcount = 8'd4; m1_address = 25'h200;
            ddr_waitrequest = 1'b1;
            #1;
            if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL wr_stall%0d_wait got=%0h exp=1", c, m1_waitrequest); end total++;
            if (ddr_read !== 1'b1) begin bad++; $display("FAIL wr_stall%0d_read got=%0h exp=1", c, ddr_read); end total++;
            if (ddr_address !== 25'h200) begin bad++; $display("FAIL wr_stall%0d_addr got=%0h exp=200", c, ddr_address); end total++;
            if (ddr_burstcount !== 8'd4) begin bad++; $display("FAIL wr_stall%0d_bc got=%0h exp=4", c, ddr_burstcount); end total++;
            $display("test_waitrequest: stall cycle %0d", c);
            step();
        end
        ddr_waitrequest = 1'b0;
        #1;
        if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL wr_accept_wait got=%0h exp=0", m1_waitrequest); end total++;
        $display("test_waitrequest: m1 read accepted");
        for (int i = 0; i < 4; i++) begin
            step();
            m1_read = 1'b0; ddr_readdatavalid = 1'b1;
            if (i == 3) begin
                m0_read = 1'b1; m0_burstcount = 8'd1; m0_address = 25'h700;
            end
            #1;
            if (m1_readdatavalid !== 1'b1) begin bad++; $display("FAIL wr_ret%0d_m1_rdv got=%0h exp=1", i, m1_readdatavalid); end total++;
            if (ddr_read !== (i == 3)) begin bad++; $display("FAIL wr_ret%0d_read got=%0h exp=%0h", i, ddr_read, (i == 3)); end total++;
            $display("test_waitrequest: m1 return beat %0d", i);
        end
        step();
        m0_read = 1'b0;
        #1;
        if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL wr_pushpop_m0_rdv got=%0h exp=1", m0_readdatavalid); end total++;
        if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL wr_pushpop_m1_rdv got=%0h exp=0", m1_readdatavalid); end total++;
        $display("test_waitrequest: read pushed during pop returned to m0");
        step();
        idle_inputs();
    endtask

    // Reset with reads outstanding abandons them; m0 wins first tie after reset.
    task automatic test_reset_abandon();
        m0_read = 1'b1; m0_burstcount = 8'd2; m0_address = 25'h10;
        m1_read = 1'b1; m1_burstcount = 8'd2; m1_address = 25'h20;
        #1;
        // Last grant before this was m0, so the tie goes to m1.
        if (ddr_address !== 25'h20) begin bad++; $display("FAIL ra_tie1_addr got=%0h exp=20", ddr_address); end total++;
        if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL ra_tie1_m1_wait got=%0h exp=0", m1_waitrequest); end total++;
        step();
        m1_read = 1'b0;
        #1;
        if (ddr_address !== 25'h10) begin bad++; $display("FAIL ra_m0_addr got=%0h exp=10", ddr_address); end total++;
        if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL ra_m0_wait got=%0h exp=0", m0_waitrequest); end total++;
        $display("test_reset_abandon: two reads outstanding");
        step();
        idle_inputs();
        reset_reset_n = 1'b0;
        step();
        step();
        reset_reset_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            step();
            ddr_readdatavalid = 1'b1;
            #1;
            if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL ra_pulse%0d_m0_rdv got=%0h exp=0", p, m0_readdatavalid); end total++;
            if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL ra_pulse%0d_m1_rdv got=%0h exp=0", p, m1_readdatavalid); end total++;
            $display("test_reset_abandon: stale beat %0d dropped", p);
        end
        step();
        ddr_readdatavalid = 1'b0;
        m0_read = 1'b1; m0_burstcount = 8'd1; m0_address = 25'h30;
        m1_read = 1'b1; m1_burstcount = 8'd1; m1_address = 25'h40;
        #1;
        if (ddr_address !== 25'h30) begin bad++; $display("FAIL ra_tie2_addr got=%0h exp=30", ddr_address); end total++;
        if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL ra_tie2_m0_wait got=%0h exp=0", m0_waitrequest); end total++;
        if (m1_waitrequest !== 1'b1) begin bad++; $display("FAIL ra_tie2_m1_wait got=%0h exp=1", m1_waitrequest); end total++;
        step();
        m0_read = 1'b0; m1_read = 1'b0; ddr_readdatavalid = 1'b1;
        #1;
        if (m0_readdatavalid !== 1'b1) begin bad++; $display("FAIL ra_fresh_m0_rdv got=%0h exp=1", m0_readdatavalid); end total++;
        if (m1_readdatavalid !== 1'b0) begin bad++; $display("FAIL ra_fresh_m1_rdv got=%0h exp=0", m1_readdatavalid); end total++;
        $display("test_reset_abandon: fresh m0 read returned to m0");
        step();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_burst();
        test_fifo_full();
        test_waitrequest();
        test_reset_abandon();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter DW, default 128, Avalon data width in bits.
REQ-002 SHALL have parameter AW, default 25, word address width.
REQ-003 SHALL have parameter BCW, default 8, burstcount width.
REQ-004 clk_clk  input  1  single clock for all logic.
REQ-005 reset_reset_n  input  1  asynchronous, active-low reset.
REQ-006 m0_address  input  AW  VGA scan-out read master address.
REQ-007 m0_read  input  1  VGA read request.
REQ-008 m0_burstcount  input  BCW  VGA read burst length.
REQ-009 m0_urgent  input  1  VGA line FIFO below low watermark.
REQ-010 m0_waitrequest  output  1  stall for m0.
REQ-011 m0_readdatavalid  output  1  read beat for m0.
REQ-012 m1_address  input  AW  HPS/pixel-writer master address.
REQ-013 m1_read, m1_write  input  1 each  m1 read/write request, never both high.
REQ-014 m1_writedata  input  DW  m1 write data.
REQ-015 m1_byteenable  input  DW/8  m1 byte enables.
REQ-016 m1_burstcount  input  BCW  m1 burst length.
REQ-017 m1_waitrequest  output  1  stall for m1.
REQ-018 m1_readdatavalid  output  1  read beat for m1.
REQ-019 rd_data  output  DW  ddr_readdata forwarded to both masters.
REQ-020 ddr_address, ddr_read, ddr_write, ddr_writedata, ddr_byteenable, ddr_burstcount  output  AW/1/1/DW/DW/8/BCW  command to FPGA DDR3 controller Avalon slave.
REQ-021 ddr_waitrequest, ddr_readdatavalid  input  1 each  slave stall and read-beat strobe.
REQ-022 ddr_readdata  input  DW  slave read data.

Function
REQ-023 SHALL use states IDLE and WBURST; reads always issue from IDLE.
REQ-024 In IDLE, SHALL select one requester combinationally and present its command on ddr_* in the same cycle (zero-cycle latency); the non-selected master sees waitrequest=1.
REQ-025 Selection: m0 if m0_read and m0_urgent; else round-robin between m0 and m1, alternating last_grant after each accepted command.
REQ-026 A command is accepted when ddr_read or ddr_write is high and ddr_waitrequest=0; the selected master's waitrequest SHALL equal ddr_waitrequest.
REQ-027 Accepted m1 write with burstcount>1 SHALL enter WBURST, lock the grant to m1, load a beat counter with burstcount-1, and decrement on each accepted beat; return to IDLE when the count reaches 0.
REQ-028 In WBURST, m0 SHALL see waitrequest=1 regardless of m0_urgent.
REQ-029 Burstcount 0 from either master SHALL be issued as 1.
REQ-030 Each accepted read SHALL push {owner, burstcount} into a 4-entry tag FIFO; when the FIFO is full, read requests SHALL see waitrequest=1 and not assert ddr_read, while m1 writes may still issue.
REQ-031 A push while full SHALL be blocked even if a pop occurs in the same cycle.
REQ-032 Each ddr_readdatavalid SHALL assert the FIFO-head owner's readdatavalid in the same cycle and increment a return-beat counter; on the beat equal to the head burstcount, pop and clear the counter.
REQ-033 Read issue and read return in the same cycle SHALL both complete, push and pop occurring together.
REQ-034 ddr_readdatavalid with the tag FIFO empty SHALL be discarded (neither master's valid asserted).
REQ-035 Idle ddr_read/ddr_write SHALL be 0; ddr_address, ddr_writedata, ddr_byteenable and ddr_burstcount are don't-care when both are 0.

Reset
REQ-036 On reset_reset_n low: state IDLE, last_grant=m1 (m0 wins the first tie), tag FIFO empty, counters 0, ddr_read=ddr_write=0, m0/m1_readdatavalid=0; waitrequests are 1 while reset is asserted.
REQ-037 Reset mid-burst or with reads outstanding SHALL abandon them; returning beats after reset fall under REQ-034.

Verification
REQ-038 m0 read burst 8 @0x100 and m1 read burst 4 @0x200 in the same cycle, no urgent, after reset -> m0 issued first, m1 next cycle; 8 m0 valids then 4 m1 valids.
REQ-039 m1 write burst 4 accepted, m0_read+m0_urgent asserted on beat 2 -> m0 stalled until the 4th write beat, then m0 issues in the following IDLE cycle.
REQ-040 5 back-to-back m0 reads of burst 2 with no data returned -> 4 accepted, 5th held with ddr_read=0; the first pop at the 2nd return beat lets it issue the following cycle.
REQ-041 ddr_waitrequest held high 3 cycles on the m1 read -> m1_waitrequest high 3 cycles, with address and burstcount stable on ddr_*.
REQ-042 Reset asserted with 2 reads outstanding, then 3 ddr_readdatavalid pulses -> no master valids asserted and FIFO still empty.
